// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART blocks: FSM states,
// parity mode constants and the rounded clock/baud divisor calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Rounded CLK_FREQ/BAUD; returns 0 when the ratio is too small to time a bit.
  function automatic int calc_div(input int clk_freq, input int baud);
    longint q;
    q = (longint'(clk_freq) + longint'(baud) / 2) / longint'(baud);
    return (q < 2) ? 0 : int'(q);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head is valid whenever level != 0.
// Pushes while full are dropped, pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & (r_level != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_param_transmitter.sv
// Parametrised UART transmitter with TX FIFO; define UART_TX_PARITY_EN to
// insert a runtime-selectable even/odd parity bit after the data bits.
module uart_param_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic                        cfg_parity_odd,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        done
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_param_transmitter: CLK_FREQ/BAUD must round to at least 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
    $error("uart_param_transmitter: DATA_W must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_param_transmitter: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_param_transmitter: FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic [DATA_W-1:0] w_head;
  logic [LW-1:0]     w_level;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_have_data;
  logic              w_tick;
  logic              w_last_stop;

  tx_state_t         r_state;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_txd;
  logic              r_done;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`else
  logic              w_unused_cfg;
  assign w_unused_cfg = cfg_parity_odd;
`endif

  assign w_push      = tx_valid & ~w_full;
  assign w_have_data = (w_level != '0);
  assign w_tick      = (r_cnt == '0);
  assign w_last_stop = (r_state == ST_STOP) && w_tick && (r_bit_idx == LAST_STOP);
  // Pop from idle, or back-to-back straight out of the final stop bit.
  assign w_pop       = w_have_data && ((r_state == ST_IDLE) || w_last_stop);

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (tx_data),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
        end
        ST_START: begin
          if (w_tick) begin
            r_state   <= ST_DATA;
            r_txd     <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
            r_cnt     <= CNT_MAX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt <= CNT_MAX;
            if (r_bit_idx == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_txd   <= r_parity;
`else
              r_state   <= ST_STOP;
              r_txd     <= 1'b1;
              r_bit_idx <= '0;
`endif
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_state   <= ST_STOP;
            r_txd     <= 1'b1;
            r_bit_idx <= '0;
            r_cnt     <= CNT_MAX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_STOP) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
              r_cnt     <= CNT_MAX;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_txd   <= 1'b1;
          r_cnt   <= '0;
        end
      endcase

      // Frame load overrides the idle/stop transitions above.
      if (w_pop) begin
        r_state <= ST_START;
        r_shift <= w_head;
        r_txd   <= 1'b0;
        r_cnt   <= CNT_MAX;
`ifdef UART_TX_PARITY_EN
        r_parity <= (^w_head) ^ (cfg_parity_odd == PARITY_ODD);
`endif
      end
    end
  end

  assign txd        = r_txd;
  assign done       = r_done;
  assign busy       = (r_state != ST_IDLE);
  assign tx_ready   = ~w_full;
  assign fifo_level = w_level;

endmodule
